trap_ctrl: RTL and testbench

Trap sequencer that drives the CSR file's trap port (we/addr/wdata, asynchronous rdata).
- Accepts masked interrupt requests (external, software, timer) and synchronous exceptions from the execute stage.
- On trap entry, saves state into mepc/mcause/mtval/mstatus, then redirects fetch to mtvec.
- On mret, restores mstatus and redirects fetch to mepc.
- Stalls the pipeline with hold_o for the whole sequence.

---
 rtl/trap_ctrl.sv | 137 +++++++++++++
 tb/tb_trap_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer: writes mepc/mcause/mtval/mstatus through the CSR trap port, then redirects fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_ctrl #(
    parameter int CSR_AW = 12,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_trap_i,
    input  logic              soft_trap_i,
    input  logic              tcmp_trap_i,
    input  logic              inst_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              exc_req_i,
    input  logic [3:0]        exc_cause_i,
    input  logic [XLEN-1:0]   exc_tval_i,
    input  logic              mret_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic              trap_csr_we_o,
    output logic [CSR_AW-1:0] trap_csr_addr_o,
    output logic [XLEN-1:0]   trap_csr_wdata_o,
    input  logic [XLEN-1:0]   trap_csr_rdata_i,
    output logic              hold_o,
    output logic              jump_o,
    output logic [XLEN-1:0]   jump_addr_o
);
    localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);

    typedef enum logic [2:0] {
        S_IDLE, S_MEPC, S_MCAUSE, S_MTVAL, S_MSTATUS, S_JUMP, S_MR_STAT, S_MR_JUMP
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] epc_q, cause_q, tval_q;

    logic            irq, accept;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] base;

    // In IDLE the address is parked on mstatus, so rdata[3] is the live MIE.
    always_comb begin
        irq       = trap_csr_rdata_i[3] & (ex_trap_i | soft_trap_i | tcmp_trap_i);
        accept    = rst_n && (state_q == S_IDLE) && inst_valid_i && (exc_req_i || mret_i || irq);
        irq_code  = ex_trap_i ? 4'd11 : (soft_trap_i ? 4'd3 : 4'd7);
        irq_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
        base      = {trap_csr_rdata_i[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    epc_q <= pc_i;
                    if (exc_req_i) begin
                        cause_q <= {{(XLEN-4){1'b0}}, exc_cause_i};
                        tval_q  <= exc_tval_i;
                        state_q <= S_MEPC;
                    end else if (mret_i) begin
                        state_q <= S_MR_STAT;
                    end else begin
                        cause_q <= irq_cause;
                        tval_q  <= '0;
                        state_q <= S_MEPC;
                    end
                end
                S_MEPC:    state_q <= S_MCAUSE;
                S_MCAUSE:  state_q <= S_MTVAL;
                S_MTVAL:   state_q <= S_MSTATUS;
                S_MSTATUS: state_q <= S_JUMP;
                S_MR_STAT: state_q <= S_MR_JUMP;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = A_MSTATUS;
        trap_csr_wdata_o = '0;
        hold_o           = 1'b0;
        jump_o           = 1'b0;
        jump_addr_o      = '0;
        case (state_q)
            S_IDLE: hold_o = accept;
            S_MEPC: begin
                hold_o = 1'b1; trap_csr_we_o = 1'b1;
                trap_csr_addr_o = A_MEPC; trap_csr_wdata_o = epc_q;
            end
            S_MCAUSE: begin
                hold_o = 1'b1; trap_csr_we_o = 1'b1;
                trap_csr_addr_o = A_MCAUSE; trap_csr_wdata_o = cause_q;
            end
            S_MTVAL: begin
                hold_o = 1'b1; trap_csr_we_o = 1'b1;
                trap_csr_addr_o = A_MTVAL; trap_csr_wdata_o = tval_q;
            end
            S_MSTATUS: begin
                // MPIE <= MIE, MIE <= 0
                hold_o = 1'b1; trap_csr_we_o = 1'b1;
                trap_csr_wdata_o    = trap_csr_rdata_i;
                trap_csr_wdata_o[7] = trap_csr_rdata_i[3];
                trap_csr_wdata_o[3] = 1'b0;
            end
            S_JUMP: begin
                trap_csr_addr_o = A_MTVEC;
                jump_o          = 1'b1;
                jump_addr_o     = base;
`ifdef TRAP_VECTORED_EN
                if (trap_csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1])
                    jump_addr_o = base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
`endif
            end
            S_MR_STAT: begin
                // MIE <= MPIE, MPIE <= 1
                hold_o = 1'b1; trap_csr_we_o = 1'b1;
                trap_csr_wdata_o    = trap_csr_rdata_i;
                trap_csr_wdata_o[3] = trap_csr_rdata_i[7];
                trap_csr_wdata_o[7] = 1'b1;
            end
            S_MR_JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = mepc_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a CSR file model, a spec-level reference model and a jump monitor.
module tb_trap_ctrl;
    localparam bit N = 1'b0, Y = 1'b1;

    logic        clk, rst_n;
    logic        ex_trap_i, soft_trap_i, tcmp_trap_i, inst_valid_i, exc_req_i, mret_i;
    logic [31:0] pc_i, exc_tval_i, mepc_i;
    logic [3:0]  exc_cause_i;
    logic        trap_csr_we_o, hold_o, jump_o;
    logic [11:0] trap_csr_addr_o;
    logic [31:0] trap_csr_wdata_o, trap_csr_rdata_i, jump_addr_o;

    trap_ctrl #(.CSR_AW(12), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_trap_i(ex_trap_i), .soft_trap_i(soft_trap_i), .tcmp_trap_i(tcmp_trap_i),
        .inst_valid_i(inst_valid_i), .pc_i(pc_i), .exc_req_i(exc_req_i),
        .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i), .mret_i(mret_i), .mepc_i(mepc_i),
        .trap_csr_we_o(trap_csr_we_o), .trap_csr_addr_o(trap_csr_addr_o),
        .trap_csr_wdata_o(trap_csr_wdata_o), .trap_csr_rdata_i(trap_csr_rdata_i),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR file environment; bench configuration writes take precedence.
    logic        cfg_we;
    logic [11:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [31:0] c_ms = 0, c_tvec = 0, c_mepc = 0, c_mcause = 0, c_mtval = 0;

    always @(posedge clk) begin
        if (cfg_we) begin
            case (cfg_addr)
                12'h300: c_ms   <= cfg_data;
                12'h305: c_tvec <= cfg_data;
                12'h341: c_mepc <= cfg_data;
                default: ;
            endcase
        end else if (trap_csr_we_o) begin
            case (trap_csr_addr_o)
                12'h300: c_ms     <= trap_csr_wdata_o;
                12'h341: c_mepc   <= trap_csr_wdata_o;
                12'h342: c_mcause <= trap_csr_wdata_o;
                12'h343: c_mtval  <= trap_csr_wdata_o;
                default: ;
            endcase
        end
    end

    always_comb begin
        trap_csr_rdata_i = 32'h0;
        case (trap_csr_addr_o)
            12'h300: trap_csr_rdata_i = c_ms;
            12'h305: trap_csr_rdata_i = c_tvec;
            12'h341: trap_csr_rdata_i = c_mepc;
            12'h342: trap_csr_rdata_i = c_mcause;
            12'h343: trap_csr_rdata_i = c_mtval;
            default: ;
        endcase
    end
    assign mepc_i = c_mepc;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h @cyc %0d", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] ja, mepc, mcause, mtval, ms;
    } exp_t;
    exp_t q[$];

    // Architectural reference state
    logic [31:0] m_ms = 0, m_tvec = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
    logic [31:0] sv_ms, sv_mcause, sv_mtval;
    int  busy = 0;
    bit  exp_hold = 0;

    function automatic logic [31:0] target(input logic [31:0] tvec, input bit is_irq, input int code);
        logic [31:0] t;
        t = tvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
        if (is_irq && (tvec & 32'h3) == 32'h1) t = t + 32'(code * 4);
`endif
        return t;
    endfunction

    task automatic tick(input bit iv, input logic [31:0] pc, input bit exc, input logic [3:0] cause,
                        input logic [31:0] tval, input bit mr, input bit e, input bit s, input bit t,
                        input bit cw, input logic [11:0] ca, input logic [31:0] cd);
        exp_t r;
        int   code;
        @(posedge clk); #1;
        inst_valid_i = iv; pc_i = pc; exc_req_i = exc; exc_cause_i = cause; exc_tval_i = tval;
        mret_i = mr; ex_trap_i = e; soft_trap_i = s; tcmp_trap_i = t;
        cfg_we = cw; cfg_addr = ca; cfg_data = cd;
        if (busy > 0) begin
            busy--;
            exp_hold = (busy > 0);
        end else if (iv && (exc || mr || (m_ms[3] && (e || s || t)))) begin
            exp_hold = 1;
            if (exc || !mr) begin
                sv_ms = m_ms; sv_mcause = m_mcause; sv_mtval = m_mtval;
                code = e ? 11 : (s ? 3 : 7);
                m_mepc   = pc;
                m_mcause = exc ? {28'h0, cause} : (32'h8000_0000 | 32'(code));
                m_mtval  = exc ? tval : 32'h0;
                m_ms     = (m_ms & ~32'h88) | (m_ms[3] ? 32'h80 : 32'h0);
                r.ja     = target(m_tvec, !exc, code);
                r.cyc    = cyc + 5;
                busy     = 5;
            end else begin
                m_ms  = (m_ms & ~32'h88) | 32'h80 | (m_ms[7] ? 32'h8 : 32'h0);
                r.ja  = m_mepc;
                r.cyc = cyc + 2;
                busy  = 2;
            end
            r.mepc = m_mepc; r.mcause = m_mcause; r.mtval = m_mtval; r.ms = m_ms;
            q.push_back(r);
        end else begin
            exp_hold = 0;
        end
        if (cw) begin
            case (ca)
                12'h300: m_ms   = cd;
                12'h305: m_tvec = cd;
                12'h341: m_mepc = cd;
                default: ;
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(N, 32'h0, N, 4'd0, 32'h0, N, N, N, N, N, 12'h0, 32'h0);
    endtask

    task automatic cfg(input logic [11:0] a, input logic [31:0] d);
        tick(N, 32'h0, N, 4'd0, 32'h0, N, N, N, N, Y, a, d);
    endtask

    task automatic exc_at(input logic [31:0] pc, input logic [3:0] c, input logic [31:0] tv);
        tick(Y, pc, Y, c, tv, N, N, N, N, N, 12'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(trap_csr_we_o), 32'h0);
        chk({tag, "_addr"},  32'(trap_csr_addr_o), 32'h300);
        chk({tag, "_wdata"}, trap_csr_wdata_o, 32'h0);
        chk({tag, "_hold"},  32'(hold_o), 32'h0);
        chk({tag, "_jump"},  32'(jump_o), 32'h0);
        chk({tag, "_jaddr"}, jump_addr_o, 32'h0);
    endtask

    // Monitor: per-cycle hold/wdata rules, and full transaction check on every jump.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("hold", 32'(hold_o), 32'(exp_hold));
            if (!trap_csr_we_o) chk("wdata_idle", trap_csr_wdata_o, 32'h0);
            if (jump_o) begin
                if (q.size() == 0) begin
                    chk("spurious_jump", 32'(jump_o), 32'h0);
                end else begin
                    exp_t r;
                    r = q.pop_front();
                    chk("jump_cycle", 32'(cyc), 32'(r.cyc));
                    chk("jump_addr", jump_addr_o, r.ja);
                    chk("mepc", c_mepc, r.mepc);
                    chk("mcause", c_mcause, r.mcause);
                    chk("mtval", c_mtval, r.mtval);
                    chk("mstatus", c_ms, r.ms);
                end
            end
        end
    end

    logic [31:0] mtab [4] = '{32'h100, 32'h201, 32'h3F0, 32'h1001};

    initial begin
        rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        inst_valid_i = 0; pc_i = 0; exc_req_i = 0; exc_cause_i = 0; exc_tval_i = 0;
        mret_i = 0; ex_trap_i = 0; soft_trap_i = 0; tcmp_trap_i = 0;
        #23;
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1;

        // ECALL
        cfg(12'h305, 32'h100); cfg(12'h300, 32'h1808);
        exc_at(32'h40, 4'd11, 32'h0);
        idle(6);
        chk("ecall_mstatus", c_ms, 32'h1880);

        // interrupt priority
        cfg(12'h300, 32'h1808);
        tick(Y, 32'h80, N, 4'd0, 32'h0, N, Y, Y, Y, N, 12'h0, 32'h0);
        idle(6);
        chk("prio_mcause", c_mcause, 32'h8000_000B);

        // MIE gating, then exception regardless of MIE
        cfg(12'h300, 32'h1800);
        repeat (4) tick(Y, 32'h88, N, 4'd0, 32'h0, N, N, N, Y, N, 12'h0, 32'h0);
        tick(Y, 32'h90, Y, 4'd2, 32'hDEAD, N, N, N, Y, N, 12'h0, 32'h0);
        idle(6);

        // MRET with a timer interrupt held pending
        cfg(12'h300, 32'h1880); cfg(12'h341, 32'h84);
        tick(Y, 32'h84, N, 4'd0, 32'h0, Y, N, N, Y, N, 12'h0, 32'h0);
        repeat (3) tick(Y, 32'h84, N, 4'd0, 32'h0, N, N, N, Y, N, 12'h0, 32'h0);
        idle(6);

        // reset in the MCAUSE state
        cfg(12'h300, 32'h1808);
        exc_at(32'hA0, 4'd5, 32'h55);
        idle(1);
        @(posedge clk); #1;
        rst_n = 0; busy = 0; exp_hold = 0; q.delete();
        m_ms = sv_ms; m_mcause = sv_mcause; m_mtval = sv_mtval;
        #1 check_reset_outputs("midseq_reset");
        chk("reset_mepc_kept", c_mepc, 32'hA0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        exc_at(32'hB0, 4'd7, 32'h77);
        idle(6);

        // vectored vs base target
        cfg(12'h305, 32'h201); cfg(12'h300, 32'h1808);
        tick(Y, 32'hC0, N, 4'd0, 32'h0, N, N, Y, N, N, 12'h0, 32'h0);
        idle(6);
        cfg(12'h300, 32'h1808);
        exc_at(32'hC4, 4'd3, 32'h0);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (busy == 0 && $urandom_range(15) == 0) begin
                if ($urandom_range(1) == 1)
                    cfg(12'h300, 32'h1800 | ($urandom_range(1) == 1 ? 32'h8 : 32'h0)
                                          | ($urandom_range(1) == 1 ? 32'h80 : 32'h0));
                else
                    cfg(12'h305, mtab[$urandom_range(3)]);
            end else begin
                tick($urandom_range(9) < 7, $urandom & 32'hFFFF_FFFC, $urandom_range(7) == 0,
                     4'($urandom_range(15)), $urandom, $urandom_range(7) == 0,
                     $urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0,
                     N, 12'h0, 32'h0);
            end
        end
        idle(8);
        chk("drain", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
